// File: rtl/spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spm_seq_ctrl
//   Sequencer for one serial-parallel multiplier (spm) datapath. It accepts an
//   unsigned operand pair, clears the spm, streams the multiplier into spm_y
//   LSB first while holding the multiplicand on spm_x, and deserialises the
//   serial product from spm_p into a 2*WIDTH result.
//
// Parameters
//   WIDTH  operand width in bits (the spm has WIDTH csa cells)
//   P_LAT  cycles from driving y bit k to product bit k appearing on spm_p (1..4)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   start_valid   operand pair available       start_ready   accepting operands
//   op_a          multiplicand (parallel)      op_b          multiplier (serial)
//   spm_x         parallel operand to spm      spm_y         serial bit to spm
//   spm_rst       spm clear, active low        spm_p         serial product bit
//   result_valid  product available            result_ready  consumer accepts
//   result        unsigned product op_a*op_b
// -----------------------------------------------------------------------------
module spm_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int P_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  output logic                 spm_rst,
  input  logic                 spm_p,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2*WIDTH-1:0]   result
);

  // RUN length: 2*WIDTH product bits plus the datapath latency.
  localparam int N     = 2*WIDTH + P_LAT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(P_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b_sh;
  logic [2*WIDTH-1:0]   r_res_sh;
  logic                 w_accept;

  assign w_accept = (r_state == S_IDLE) && start_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    spm_y        = 1'b0;
    spm_rst      = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        spm_rst = 1'b1;
        spm_y   = r_b_sh[0];
        if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        spm_rst      = 1'b1;
        result_valid = 1'b1;
        result       = r_res_sh;
        if (result_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The multiplicand must stay on spm_x for the whole operation, so it is
  // only reloaded on accept.
  assign spm_x = r_a;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= op_a;
      r_b_sh   <= op_b;
      r_res_sh <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      // Zero-fill supplies the upper WIDTH y bits that flush the carries.
      r_b_sh <= r_b_sh >> 1;
      // The first P_LAT spm_p bits precede product bit 0; skip them.
      if (r_cnt >= CAP_CNT) begin
        r_res_sh <= {spm_p, r_res_sh[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
module tb_spm_seq_ctrl;

  localparam int W     = 8;
  localparam int P_LAT = 1;
  localparam int N     = 2*W + P_LAT;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     spm_x;
  logic             spm_y;
  logic             spm_rst;
  logic             spm_p;
  logic             result_valid;
  logic             result_ready;
  logic [2*W-1:0]   result;

  spm_seq_ctrl #(.WIDTH(W), .P_LAT(P_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .spm_x        (spm_x),
    .spm_y        (spm_y),
    .spm_rst      (spm_rst),
    .spm_p        (spm_p),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural spm: shift-add serial multiplier, one output register.
  logic [2*W:0] m_s;
  logic [2*W:0] m_sum;
  logic         m_p;
  assign spm_p = m_p;

  always @(posedge clk) begin
    if (!spm_rst) begin
      m_s <= '0;
      m_p <= 1'b0;
    end else begin
      m_sum = m_s + (spm_y ? {{(W+1){1'b0}}, spm_x} : '0);
      m_p   <= m_sum[0];
      m_s   <= m_sum >> 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [2*W-1:0] exp_q[$];

  int       gcyc = 0;
  always @(posedge clk) gcyc++;

  // Monitor state
  bit       mon_en = 0;
  bit       in_op  = 0;
  int       cyc    = 0;
  logic [W-1:0] cur_a, cur_b;
  bit       b2b_chk = 0;
  bit       hs_seen = 0;
  int       hs_e    = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_op) cyc++;
      if (!in_op) begin
        check("idle_start_ready", start_ready, 1'b1);
        check("idle_result_valid", result_valid, 1'b0);
        check("idle_spm_rst", spm_rst, 1'b0);
        check("idle_spm_y", spm_y, 1'b0);
      end else if (cyc == 1) begin
        check("clear_spm_rst", spm_rst, 1'b0);
        check("clear_spm_y", spm_y, 1'b0);
        check("clear_spm_x", spm_x, cur_a);
        check("clear_start_ready", start_ready, 1'b0);
        check("clear_result_valid", result_valid, 1'b0);
      end else if (cyc <= N + 1) begin
        int r;
        logic exp_y;
        r = cyc - 2;
        exp_y = (r < W) ? cur_b[r[2:0]] : 1'b0;
        check("run_spm_rst", spm_rst, 1'b1);
        check("run_spm_x", spm_x, cur_a);
        check("run_spm_y", spm_y, exp_y);
        check("run_start_ready", start_ready, 1'b0);
        check("run_result_valid", result_valid, 1'b0);
      end else begin
        check("done_result_valid", result_valid, 1'b1);
        check("done_start_ready", start_ready, 1'b0);
        check("done_spm_y", spm_y, 1'b0);
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else check("result", result, exp_q[0]);
      end

      if (!rst) begin
        in_op = 0;
      end else if (in_op && result_valid && result_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs_e    = gcyc + 1;
        hs_seen = 1;
        in_op   = 0;
      end else if (!in_op && start_valid && start_ready) begin
        if (b2b_chk && hs_seen) check("b2b_accept_gap", gcyc + 1 - hs_e, 1);
        cur_a = op_a;
        cur_b = op_b;
        cyc   = 0;
        in_op = 1;
      end
    end
  end

  // Drives one operand pair; returns #1 after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bit ok;
    ok = 0;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (start_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept_timeout", ok, 1'b1);
    if (ok) exp_q.push_back((2*W)'(a) * (2*W)'(b));
    @(posedge clk);
    #1;
    if (!hold) start_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("done_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nv;
    bit ok;
    rst = 1'b0;
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    result_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_spm_x", spm_x, 8'h00);
    check("rst_spm_y", spm_y, 1'b0);
    check("rst_spm_rst", spm_rst, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // 1: latency and single-cycle valid pulse
    send(8'h0F, 8'h0F, 0);
    k = 0;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      k++;
      if (result_valid) begin
        ok = 1;
        break;
      end
    end
    check("t1_valid_seen", ok, 1'b1);
    check("t1_latency", k, 19);
    check("t1_result", result, 16'h00E1);
    @(negedge clk);
    check("t1_valid_pulse", result_valid, 1'b0);
    wait_done();

    // 2: assorted operands
    send(8'hFF, 8'hFF, 0);
    wait_done();
    send(8'h00, 8'hA5, 0);
    wait_done();
    send(8'h01, 8'h80, 0);
    wait_done();

    // 3: backpressure
    result_ready = 1'b0;
    send(8'hFF, 8'hFF, 0);
    start_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (result_valid) begin
        ok = 1;
        break;
      end
    end
    check("t3_valid_seen", ok, 1'b1);
    nv = 1;
    repeat (4) begin
      @(negedge clk);
      if (result_valid) nv++;
      check("t3_hold_result", result, 16'hFE01);
    end
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    start_valid = 1'b0;
    @(negedge clk);
    if (result_valid) nv++;
    @(negedge clk);
    check("t3_valid_cycles", nv, 6);
    check("t3_released", result_valid, 1'b0);
    wait_done();

    // 4: reset during RUN at cnt=6
    send(8'h37, 8'h59, 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("t4_start_ready", start_ready, 1'b1);
    check("t4_result_valid", result_valid, 1'b0);
    check("t4_spm_rst", spm_rst, 1'b0);
    check("t4_spm_y", spm_y, 1'b0);
    check("t4_spm_x", spm_x, 8'h00);
    check("t4_result", result, 16'h0000);
    send(8'h03, 8'h05, 0);
    wait_done();

    // 5: back-to-back with start_valid held
    hs_seen = 0;
    b2b_chk = 1;
    send(8'h12, 8'h34, 1);
    send(8'hAB, 8'hCD, 0);
    wait_done();
    b2b_chk = 0;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
Sequencer for the serial-parallel multiplier (spm) datapath, the chain of carry-save cells driven by a parallel operand x and a serial operand y.
- Accepts one unsigned operand pair over a valid/ready handshake.
- Clears the datapath, streams the multiplier LSB-first into y, and deserialises the serial product into a 2*WIDTH result.
- Presents the result over a second valid/ready handshake.
- Sits between the host interface and one spm instance; the spm instance is not shared.

Parameters:
WIDTH, 32, operand width in bits; the spm instance has WIDTH csa cells.
P_LAT, 1, cycles from driving product bit k's y bit to that bit appearing on spm_p (1..4).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-low reset
start_valid  in  1  operand pair available
start_ready  out  1  controller can accept operands
op_a  in  WIDTH  multiplicand (parallel operand)
op_b  in  WIDTH  multiplier (serial operand)
spm_x  out  WIDTH  parallel operand to the datapath
spm_y  out  1  serial operand bit to the datapath
spm_rst  out  1  datapath synchronous, active-low clear
spm_p  in  1  serial product bit from the datapath
result_valid  out  1  product available
result_ready  in  1  consumer accepts product
result  out  2*WIDTH  unsigned product op_a*op_b

Behaviour:
Reset (rst=0 at a clk edge), regardless of current state:
- Go to IDLE; counter cleared; a_reg, b_sh and res_sh cleared.
- Outputs after reset: start_ready=1, result_valid=0, result=0, spm_x=0, spm_y=0, spm_rst=0.
- Reset mid-operation abandons the operation with no partial result.

Datapath drive:
- spm_x = a_reg at all times.
- spm_y = b_sh[0] in RUN, 0 otherwise.
- spm_rst = 0 in IDLE and CLEAR, 1 in RUN and DONE.

FSM states:
- IDLE
  - start_ready=1.
  - On start_valid: a_reg<=op_a, b_sh<=op_b, res_sh<=0, cnt<=0, go to CLEAR.
- CLEAR
  - Exactly one cycle with spm_rst=0 and a_reg stable; go to RUN.
- RUN
  - Lasts N = 2*WIDTH+P_LAT cycles; cnt counts 0..N-1.
  - Each cycle: b_sh <= b_sh>>1, zero-fill. Bits WIDTH..2*WIDTH-1 of the y stream are 0.
  - When cnt >= P_LAT: res_sh <= {spm_p, res_sh[2*WIDTH-1:1]}. After the last capture, the LSB is in res_sh[0].
  - At cnt = N-1, go to DONE.
- DONE
  - result_valid=1 and result=res_sh.
  - Both hold stable until result_ready=1 at a clk edge, then go to IDLE.

Handshake and timing:
- start_ready is 1 only in IDLE; start_valid is ignored in every other state.
- A new start cannot be accepted in the same cycle as the result handshake; the next start is accepted in the following IDLE cycle at the earliest.
- Latency: with the accept edge as cycle 0, result_valid first reads 1 in cycle 2*WIDTH+P_LAT+2.
- Throughput: one product per 2*WIDTH+P_LAT+3 cycles without backpressure.

Widths and arithmetic:
- cnt width is clog2(2*WIDTH+P_LAT+1).
- Unsigned only; the product never overflows 2*WIDTH bits.
- The controller performs no arithmetic on the product; correctness relies on spm_p.

Test Plan:
Bench setup: WIDTH=8, P_LAT=1, spm instance modelled behaviourally. In the model, spm_p is the serial LSB-first product, delayed P_LAT cycles and cleared by spm_rst.
1. op_a=0x0F, op_b=0x0F, result_ready=1 -> result=0x00E1; result_valid first reads 1 in cycle 19 after accept and is high for one cycle.
2. op_a=0xFF, op_b=0xFF -> result=0xFE01; op_a=0x00, op_b=0xA5 -> result=0x0000; op_a=0x01, op_b=0x80 -> result=0x0080.
3. Backpressure: result_ready=0 for 5 cycles after result_valid rises -> result_valid and result hold at 0xFE01; start_ready stays 0 with start_valid=1; transfer completes on the cycle result_ready=1.
4. rst=0 for one cycle at RUN cycle cnt=6 -> next cycle start_ready=1, result_valid=0, spm_rst=0, spm_y=0. A following op_a=0x03, op_b=0x05 gives result=0x000F, uncorrupted.
5. Back-to-back with start_valid held 1: pairs (0x12,0x34) then (0xAB,0xCD).
   - Results 0x03A8 then 0x88EF.
   - Second accept occurs exactly 1 cycle after the first result handshake.
   - spm_rst is low for exactly one CLEAR cycle before each RUN.
6. Protocol check on every run: spm_x equals captured op_a throughout CLEAR/RUN; spm_y is 0 outside RUN and for the last WIDTH+P_LAT RUN cycles; op_a/op_b changes after accept do not affect result.
